// File: rtl/bounce_generator.sv
// Mechanical switch emulator: turns a clean level into a chattering burst followed by
// a stable settle window, signalling settle_done once the output is stable at the new level.
module bounce_generator #(
  parameter int          N          = 8,
  parameter int          BOUNCE_LEN = 200,
  parameter int          SETTLE_LEN = 50,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic level_in,
  output logic sw_out,
  output logic busy,
  output logic settle_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // An all-zero seed would lock the LFSR, so it is swapped for the default seed.
  localparam logic [15:0] SEED_EFF    = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [N-1:0] BOUNCE_LOAD = N'(BOUNCE_LEN - 1);
  localparam logic [N-1:0] SETTLE_LOAD = N'(SETTLE_LEN - 1);
  localparam logic [N-1:0] CNT_ONE     = N'(1);
  localparam logic [N-1:0] CNT_ZERO    = N'(0);

  // Fibonacci LFSR, taps 16,14,13,11, feedback shifted in at bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  state_t       state_r, state_s;
  logic [N-1:0] cnt_r, cnt_s;
  logic [15:0]  lfsr_r;
  logic         stable_r, stable_s;
  logic         target_r, target_s;
  logic         sw_s, busy_s, done_s;
  logic         restart_s;

  // Free-running chatter source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r <= SEED_EFF;
    end else begin
      lfsr_r <= lfsr_step(lfsr_r);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      stable_r    <= 1'b0;
      target_r    <= 1'b0;
      sw_out      <= 1'b0;
      busy        <= 1'b0;
      settle_done <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      stable_r    <= stable_s;
      target_r    <= target_s;
      sw_out      <= sw_s;
      busy        <= busy_s;
      settle_done <= done_s;
    end
  end

  // Next-state and next-output decode; a level change mid-burst beats a window expiry.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    stable_s  = stable_r;
    target_s  = target_r;
    sw_s      = sw_out;
    done_s    = 1'b0;
    restart_s = en && (level_in != target_r);

    if (!en) begin
      state_s  = IDLE;
      stable_s = level_in;
      target_s = level_in;
      sw_s     = level_in;
    end else begin
      case (state_r)
        IDLE: begin
          if (level_in != stable_r) begin
            state_s  = BOUNCE;
            target_s = level_in;
            cnt_s    = BOUNCE_LOAD;
            sw_s     = level_in;
          end else begin
            sw_s = stable_r;
          end
        end
        BOUNCE: begin
          if (restart_s) begin
            target_s = level_in;
            cnt_s    = BOUNCE_LOAD;
            sw_s     = level_in;
          end else if (cnt_r == CNT_ZERO) begin
            state_s = SETTLE;
            cnt_s   = SETTLE_LOAD;
            sw_s    = target_r;
          end else begin
            cnt_s = cnt_r - CNT_ONE;
            sw_s  = lfsr_r[0];
          end
        end
        SETTLE: begin
          if (restart_s) begin
            state_s  = BOUNCE;
            target_s = level_in;
            cnt_s    = BOUNCE_LOAD;
            sw_s     = level_in;
          end else if (cnt_r == CNT_ZERO) begin
            state_s  = IDLE;
            stable_s = target_r;
            sw_s     = target_r;
            done_s   = 1'b1;
          end else begin
            cnt_s = cnt_r - CNT_ONE;
            sw_s  = target_r;
          end
        end
        default: begin
          state_s = IDLE;
          sw_s    = stable_r;
        end
      endcase
    end

    busy_s = (state_s != IDLE);
  end

endmodule

// File: tb/tb_bounce_generator.sv
// Directed bench for bounce_generator with BL=20, SL=10: bypass, nominal burst,
// restarts in BOUNCE and SETTLE, and asynchronous reset mid-burst.
module tb_bounce_generator;

  localparam int BL = 20;
  localparam int SL = 10;

  logic clk = 1'b0;
  logic rst, en, level_in;
  logic sw_out, busy, settle_done;
  logic [15:0] m_lfsr;
  int checks = 0;
  int errors = 0;

  bounce_generator #(
    .N(8), .BOUNCE_LEN(BL), .SETTLE_LEN(SL), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .level_in(level_in),
    .sw_out(sw_out), .busy(busy), .settle_done(settle_done)
  );

  always #5 clk = ~clk;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic s, input logic b, input logic d);
    check({tag, ".sw_out"}, {31'd0, sw_out}, {31'd0, s});
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    check({tag, ".settle_done"}, {31'd0, settle_done}, {31'd0, d});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_sw;
    logic prev_sw;
    int   toggles;

    rst = 1'b0; en = 1'b0; level_in = 1'b0;

    // 1: asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1 expect_out("t1_async_rst", 1'b0, 1'b0, 1'b0);
    tick; tick;
    #3 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick; expect_out("t1_idle", 1'b0, 1'b0, 1'b0);
    end

    // 2: bypass, one-cycle latency, never busy
    level_in = 1'b1;
    check("t2_before", {31'd0, sw_out}, 32'd0);
    tick; expect_out("t2_bypass_hi", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick; expect_out("t2_bypass_hold", 1'b1, 1'b0, 1'b0);
    end
    level_in = 1'b0;
    tick; expect_out("t2_bypass_lo", 1'b0, 1'b0, 1'b0);

    // 3: nominal burst
    en = 1'b1;
    tick; expect_out("t3_en_no_burst", 1'b0, 1'b0, 1'b0);
    level_in = 1'b1;
    tick; expect_out("t3_e0", 1'b1, 1'b1, 1'b0);
    prev_sw = 1'b1;
    toggles = 0;
    for (int e = 1; e < BL; e++) begin
      exp_sw = m_lfsr[0];
      tick; expect_out("t3_chatter", exp_sw, 1'b1, 1'b0);
      if (sw_out != prev_sw) toggles++;
      prev_sw = sw_out;
    end
    check("t3_toggle", {31'd0, (toggles >= 1)}, 32'd1);
    for (int e = BL; e < BL + SL; e++) begin
      tick; expect_out("t3_settle", 1'b1, 1'b1, 1'b0);
    end
    tick; expect_out("t3_done", 1'b1, 1'b0, 1'b1);
    tick; expect_out("t3_after", 1'b1, 1'b0, 1'b0);

    // return to 0 through bypass
    en = 1'b0; level_in = 1'b0;
    tick; expect_out("bypass_lo", 1'b0, 1'b0, 1'b0);
    en = 1'b1;

    // 4: restart during BOUNCE at E10
    level_in = 1'b1;
    tick; expect_out("t4_e0", 1'b1, 1'b1, 1'b0);
    for (int e = 1; e < 10; e++) begin
      tick; check("t4_busy", {31'd0, busy}, 32'd1);
    end
    level_in = 1'b0;
    tick; expect_out("t4_restart", 1'b0, 1'b1, 1'b0);
    for (int e = 11; e < 30; e++) begin
      tick;
      check("t4_no_done", {31'd0, settle_done}, 32'd0);
      check("t4_busy2", {31'd0, busy}, 32'd1);
    end
    for (int e = 30; e < 40; e++) begin
      tick; expect_out("t4_settle", 1'b0, 1'b1, 1'b0);
    end
    tick; expect_out("t4_done", 1'b0, 1'b0, 1'b1);

    // 5: restart during SETTLE at E25
    level_in = 1'b1;
    tick; expect_out("t5_e0", 1'b1, 1'b1, 1'b0);
    for (int e = 1; e < 25; e++) begin
      tick;
      check("t5_busy", {31'd0, busy}, 32'd1);
      if (e >= BL) check("t5_settle_sw", {31'd0, sw_out}, 32'd1);
    end
    level_in = 1'b0;
    tick; expect_out("t5_restart", 1'b0, 1'b1, 1'b0);
    exp_sw = m_lfsr[0];
    tick; expect_out("t5_rebounce", exp_sw, 1'b1, 1'b0);
    for (int e = 27; e < 55; e++) begin
      tick;
      check("t5_no_done", {31'd0, settle_done}, 32'd0);
      check("t5_busy2", {31'd0, busy}, 32'd1);
    end
    tick; expect_out("t5_done", 1'b0, 1'b0, 1'b1);

    // 6: asynchronous reset mid-burst at E7
    level_in = 1'b1;
    tick; expect_out("t6_e0", 1'b1, 1'b1, 1'b0);
    for (int e = 1; e < 7; e++) tick;
    #2 rst = 1'b1;
    #1 expect_out("t6_async_rst", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 expect_out("t6_rst_held", 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    tick; expect_out("t6_new_e0", 1'b1, 1'b1, 1'b0);
    exp_sw = m_lfsr[0];
    tick; expect_out("t6_e1", exp_sw, 1'b1, 1'b0);
    for (int e = 2; e < BL + SL; e++) begin
      tick; check("t6_no_done", {31'd0, settle_done}, 32'd0);
    end
    tick; expect_out("t6_done", 1'b1, 1'b0, 1'b1);
    tick; expect_out("t6_after", 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
